// File: rtl/load_store_queue.sv
// -----------------------------------------------------------------------------
// load_store_queue
//
// In-order load/store queue that sits between the load/store reservation
// station and the single data-memory port. Entries are allocated at dispatch
// in program order. The address adder later fills in the effective address and
// store data. Only the oldest entry (head) is ever sent to memory:
//   - a load may go as soon as its address is known; its result is broadcast
//     on the CDB,
//   - a store also waits until its ROB entry is the ROB head, so memory is
//     only written by instructions that can no longer be squashed.
//
// Handshakes:
//   dispatch_valid : the producer asserts it only while lsq_full is low. A
//                    dispatch seen while full, or in a flush cycle, is dropped.
//   agu_valid/agu_resp : the producer holds tag/addr/data stable until
//                    agu_resp. agu_resp is combinational and is high in the
//                    cycle the values are captured.
//   dmem_rmask/dmem_wmask : a nonzero mask is a request. Address, masks and
//                    wdata stay stable until the cycle dmem_resp is high. The
//                    masks drop to zero in the following cycle.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   flush               synchronous squash of every entry (mispredict)
//   dispatch_*          allocation request: ROB tag, load/store, funct3
//   lsq_full            no free entry
//   agu_*               effective address and store data for a tag; agu_resp acks
//   rob_head_valid/tag  current ROB head, which gates store issue
//   dmem_*              data memory request/response port
//   cdb_*               load result broadcast (1-cycle pulse)
//   store_done*         store written to memory (1-cycle pulse)
//   dbg_state           FSM state: 0 = IDLE, 1 = WAIT, 2 = DRAIN
// -----------------------------------------------------------------------------
module load_store_queue #(
    parameter int  LSQ_DEPTH = 4,
    parameter int  ROB_DEPTH = 4,
    localparam int T         = $clog2(ROB_DEPTH),
    localparam int PW        = $clog2(LSQ_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          dispatch_valid,
    input  logic [T-1:0]  dispatch_tag,
    input  logic          dispatch_is_store,
    input  logic [2:0]    dispatch_funct3,
    output logic          lsq_full,
    input  logic          agu_valid,
    input  logic [T-1:0]  agu_tag,
    input  logic [31:0]   agu_addr,
    input  logic [31:0]   agu_store_data,
    output logic          agu_resp,
    input  logic          rob_head_valid,
    input  logic [T-1:0]  rob_head_tag,
    output logic [31:0]   dmem_addr,
    output logic [3:0]    dmem_rmask,
    output logic [3:0]    dmem_wmask,
    output logic [31:0]   dmem_wdata,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_resp,
    output logic          cdb_valid,
    output logic [T-1:0]  cdb_tag,
    output logic [31:0]   cdb_data,
    output logic          store_done,
    output logic [T-1:0]  store_done_tag,
    output logic [1:0]    dbg_state
);

    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // ---------------- queue storage ----------------
    logic [LSQ_DEPTH-1:0] valid_q, valid_d;
    logic [LSQ_DEPTH-1:0] addr_rdy_q, addr_rdy_d;
    logic [LSQ_DEPTH-1:0] is_store_q, is_store_d;
    logic [T-1:0]         tag_q      [LSQ_DEPTH];
    logic [T-1:0]         tag_d      [LSQ_DEPTH];
    logic [2:0]           funct3_q   [LSQ_DEPTH];
    logic [2:0]           funct3_d   [LSQ_DEPTH];
    logic [31:0]          ent_addr_q [LSQ_DEPTH];
    logic [31:0]          ent_addr_d [LSQ_DEPTH];
    logic [31:0]          ent_data_q [LSQ_DEPTH];
    logic [31:0]          ent_data_d [LSQ_DEPTH];
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;

    // ---------------- FSM and registered outputs ----------------
    state_t               state_q, state_d;
    logic [31:0]          dmem_addr_q, dmem_addr_d;
    logic [3:0]           rmask_q, rmask_d;
    logic [3:0]           wmask_q, wmask_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [T-1:0]         cdb_tag_q, cdb_tag_d;
    logic [31:0]          cdb_data_q, cdb_data_d;
    logic                 store_done_q, store_done_d;
    logic [T-1:0]         store_done_tag_q, store_done_tag_d;

    logic [LSQ_DEPTH-1:0] agu_hit;
    logic                 enq, deq;
    logic                 head_elig;
    logic [31:0]          h_addr, h_data;
    logic [2:0]           h_funct3;
    logic [T-1:0]         h_tag;
    logic                 h_store;
    logic [1:0]           h_off;

    // Byte-lane mask. The shift happens in a 4-bit context, so a misaligned
    // half-word at offset 3 simply loses its upper lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] rdata,
                                             input logic [1:0] off);
        logic [31:0] s;
        logic [31:0] r;
        s = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b100:  r = {24'b0, s[7:0]};
            3'b101:  r = {16'b0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    assign h_addr   = ent_addr_q[head_q];
    assign h_data   = ent_data_q[head_q];
    assign h_funct3 = funct3_q[head_q];
    assign h_tag    = tag_q[head_q];
    assign h_store  = is_store_q[head_q];
    assign h_off    = h_addr[1:0];

    assign head_elig = valid_q[head_q] & addr_rdy_q[head_q] &
                       (~h_store | (rob_head_valid & (rob_head_tag == h_tag)));

    always_comb begin
        agu_hit = '0;
        for (int i = 0; i < LSQ_DEPTH; i++) begin
            agu_hit[i] = valid_q[i] & ~addr_rdy_q[i] & (tag_q[i] == agu_tag);
        end
    end

    assign agu_resp = agu_valid & (|agu_hit);
    assign lsq_full = (count_q == CW'(LSQ_DEPTH));
    // lsq_full is sampled from the current count, so a dequeue in the same
    // cycle does not let a dispatch through.
    assign enq      = dispatch_valid & ~lsq_full & ~flush;
    assign deq      = (state_q == S_WAIT) & dmem_resp & ~flush;

    // ---------------- queue next state ----------------
    always_comb begin
        valid_d    = valid_q;
        addr_rdy_d = addr_rdy_q;
        is_store_d = is_store_q;
        tag_d      = tag_q;
        funct3_d   = funct3_q;
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (flush) begin
            valid_d    = '0;
            addr_rdy_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            // Capture only touches entries that are already valid, so it never
            // collides with the slot being allocated in the same cycle.
            if (agu_valid) begin
                for (int i = 0; i < LSQ_DEPTH; i++) begin
                    if (agu_hit[i]) begin
                        addr_rdy_d[i] = 1'b1;
                        ent_addr_d[i] = agu_addr;
                        ent_data_d[i] = agu_store_data;
                    end
                end
            end
            if (enq) begin
                valid_d[tail_q]    = 1'b1;
                addr_rdy_d[tail_q] = 1'b0;
                is_store_d[tail_q] = dispatch_is_store;
                tag_d[tail_q]      = dispatch_tag;
                funct3_d[tail_q]   = dispatch_funct3;
                tail_d             = tail_q + PW'(1);
            end
            if (deq) begin
                valid_d[head_q]    = 1'b0;
                addr_rdy_d[head_q] = 1'b0;
                head_d             = head_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            addr_rdy_q <= '0;
            is_store_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < LSQ_DEPTH; i++) begin
                tag_q[i]      <= '0;
                funct3_q[i]   <= '0;
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            addr_rdy_q <= addr_rdy_d;
            is_store_q <= is_store_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            tag_q      <= tag_d;
            funct3_q   <= funct3_d;
            ent_addr_q <= ent_addr_d;
            ent_data_q <= ent_data_d;
        end
    end

    // ---------------- memory FSM next state / outputs ----------------
    always_comb begin
        state_d          = state_q;
        dmem_addr_d      = dmem_addr_q;
        rmask_d          = rmask_q;
        wmask_d          = wmask_q;
        wdata_d          = wdata_q;
        cdb_valid_d      = 1'b0;
        cdb_tag_d        = cdb_tag_q;
        cdb_data_d       = cdb_data_q;
        store_done_d     = 1'b0;
        store_done_tag_d = store_done_tag_q;

        case (state_q)
            S_IDLE: begin
                if (!flush && head_elig) begin
                    dmem_addr_d = {h_addr[31:2], 2'b00};
                    if (h_store) begin
                        rmask_d = 4'b0000;
                        wmask_d = lane_mask(h_funct3[1:0], h_off);
                        wdata_d = h_data << {h_off, 3'b000};
                    end else begin
                        rmask_d = lane_mask(h_funct3[1:0], h_off);
                        wmask_d = 4'b0000;
                        wdata_d = '0;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_resp) begin
                    // A flush that coincides with the response just drops the
                    // result; there is nothing left to drain.
                    rmask_d = 4'b0000;
                    wmask_d = 4'b0000;
                    state_d = S_IDLE;
                    if (!flush) begin
                        if (h_store) begin
                            store_done_d     = 1'b1;
                            store_done_tag_d = h_tag;
                        end else begin
                            cdb_valid_d = 1'b1;
                            cdb_tag_d   = h_tag;
                            cdb_data_d  = load_ext(h_funct3, dmem_rdata, h_off);
                        end
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The request is still outstanding at memory, so keep it on the
                // port until it completes and then discard the response.
                if (dmem_resp) begin
                    rmask_d = 4'b0000;
                    wmask_d = 4'b0000;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            dmem_addr_q      <= '0;
            rmask_q          <= '0;
            wmask_q          <= '0;
            wdata_q          <= '0;
            cdb_valid_q      <= 1'b0;
            cdb_tag_q        <= '0;
            cdb_data_q       <= '0;
            store_done_q     <= 1'b0;
            store_done_tag_q <= '0;
        end else begin
            state_q          <= state_d;
            dmem_addr_q      <= dmem_addr_d;
            rmask_q          <= rmask_d;
            wmask_q          <= wmask_d;
            wdata_q          <= wdata_d;
            cdb_valid_q      <= cdb_valid_d;
            cdb_tag_q        <= cdb_tag_d;
            cdb_data_q       <= cdb_data_d;
            store_done_q     <= store_done_d;
            store_done_tag_q <= store_done_tag_d;
        end
    end

    assign dmem_addr      = dmem_addr_q;
    assign dmem_rmask     = rmask_q;
    assign dmem_wmask     = wmask_q;
    assign dmem_wdata     = wdata_q;
    // A flush in the same cycle as a pending pulse squashes it.
    assign cdb_valid      = cdb_valid_q & ~flush;
    assign cdb_tag        = cdb_tag_q;
    assign cdb_data       = cdb_data_q;
    assign store_done     = store_done_q & ~flush;
    assign store_done_tag = store_done_tag_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Testbench for load_store_queue: reset checks, a table of single-op vectors,
// hand-written multi-cycle sequences (store gating, fill/wrap, flush/drain,
// async reset mid-request), then randomized batches against a reference model.
module tb_load_store_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dispatch_valid;
  logic [1:0]  dispatch_tag;
  logic        dispatch_is_store;
  logic [2:0]  dispatch_funct3;
  logic        lsq_full;
  logic        agu_valid;
  logic [1:0]  agu_tag;
  logic [31:0] agu_addr;
  logic [31:0] agu_store_data;
  logic        agu_resp;
  logic        rob_head_valid;
  logic [1:0]  rob_head_tag;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        cdb_valid;
  logic [1:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        store_done;
  logic [1:0]  store_done_tag;
  logic [1:0]  dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  load_store_queue #(.LSQ_DEPTH(4), .ROB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_tag(dispatch_tag),
    .dispatch_is_store(dispatch_is_store), .dispatch_funct3(dispatch_funct3),
    .lsq_full(lsq_full),
    .agu_valid(agu_valid), .agu_tag(agu_tag), .agu_addr(agu_addr),
    .agu_store_data(agu_store_data), .agu_resp(agu_resp),
    .rob_head_valid(rob_head_valid), .rob_head_tag(rob_head_tag),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .store_done(store_done), .store_done_tag(store_done_tag),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    int off;
    int nb;
    m = 4'b0000;
    off = int'(a % 4);
    nb = nbytes(f3);
    if (nb == 4) return 4'b1111;
    for (int j = 0; j < nb; j++) begin
      if (off + j < 4) m[off + j] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] v;
    v = 64'(d) * (64'd1 << (8 * (a % 4)));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [63:0] v;
    int nb;
    nb = nbytes(f3);
    v = 64'(rd) / (64'd1 << (8 * (a % 4)));
    if (nb < 4) begin
      v = v % (64'd1 << (8 * nb));
      if (f3[2] == 1'b0 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    end
    return v[31:0];
  endfunction

  // ---------------- driver tasks (all run on the falling edge) ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_dispatch(input logic [1:0] tag, input logic st, input logic [2:0] f3);
    dispatch_valid = 1'b1; dispatch_tag = tag; dispatch_is_store = st; dispatch_funct3 = f3;
    cyc();
    dispatch_valid = 1'b0;
  endtask

  task automatic do_agu(input logic [1:0] tag, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_ack);
    agu_valid = 1'b1; agu_tag = tag; agu_addr = a; agu_store_data = d;
    #1;
    chk($sformatf("agu_resp_tag%0d", tag), 32'(agu_resp), 32'(exp_ack));
    cyc();
    agu_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if ((dmem_rmask | dmem_wmask) != 4'b0000) ok = 1'b1;
      else cyc();
    end
    chk("req_seen", 32'(ok), 32'd1);
  endtask

  // Waits for the head request, checks it, holds it for 'hold' cycles, then
  // answers and checks the completion pulse.
  task automatic serve_op(input logic [1:0] tag, input logic st, input logic [31:0] rdata,
                          input int hold, input logic [31:0] exp_addr,
                          input logic [3:0] exp_mask, input logic [31:0] exp_out);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    chk("dmem_addr", dmem_addr, exp_addr);
    if (st) begin
      chk("wmask", 32'(dmem_wmask), 32'(exp_mask));
      chk("rmask_on_store", 32'(dmem_rmask), 32'd0);
      chk("wdata", dmem_wdata, exp_out);
    end else begin
      chk("rmask", 32'(dmem_rmask), 32'(exp_mask));
      chk("wmask_on_load", 32'(dmem_wmask), 32'd0);
    end
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk("mask_held", 32'(dmem_rmask | dmem_wmask), 32'(exp_mask));
    end
    dmem_resp = 1'b1; dmem_rdata = rdata;
    cyc();
    dmem_resp = 1'b0; dmem_rdata = $urandom;
    chk("mask_clear", 32'(dmem_rmask | dmem_wmask), 32'd0);
    if (st) begin
      chk("store_done", 32'(store_done), 32'd1);
      chk("store_done_tag", 32'(store_done_tag), 32'(tag));
      chk("cdb_on_store", 32'(cdb_valid), 32'd0);
    end else begin
      chk("cdb_valid", 32'(cdb_valid), 32'd1);
      chk("cdb_tag", 32'(cdb_tag), 32'(tag));
      chk("cdb_data", cdb_data, exp_out);
      chk("store_done_on_load", 32'(store_done), 32'd0);
    end
    cyc();
    chk("pulse_one_cycle", 32'(cdb_valid | store_done), 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;      // rdata for loads, store data for stores
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_out;   // cdb_data for loads, dmem_wdata for stores
  } vec_t;

  typedef struct {
    logic [1:0]  tag;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  vec_t        vecs [12];
  op_t         op_q [$];
  logic [2:0]  lf3 [5];
  logic [2:0]  sf3 [3];

  initial begin
    bit          ok;
    int          k;
    int          r;
    int          tmp;
    int          tg [4];
    int          ord [4];
    op_t         op;
    op_t         cur;
    logic [31:0] rd;
    logic [31:0] eo;

    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h8899_AABB, 32'h0000_0100, 4'b1111, 32'h8899_AABB};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h8012_3456, 32'h0000_0100, 4'b1000, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h8012_3456, 32'h0000_0100, 4'b1000, 32'h0000_0080};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'hBEEF_0000, 32'h0000_0100, 4'b1100, 32'hFFFF_BEEF};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0102, 32'hBEEF_0000, 32'h0000_0100, 4'b1100, 32'h0000_BEEF};
    vecs[5]  = '{1'b0, 3'b000, 32'h0000_0201, 32'h0000_7F00, 32'h0000_0200, 4'b0010, 32'h0000_007F};
    vecs[6]  = '{1'b0, 3'b001, 32'h0000_0203, 32'h8100_0000, 32'h0000_0200, 4'b1000, 32'h0000_0081};
    vecs[7]  = '{1'b1, 3'b000, 32'h0000_0301, 32'hAAAA_AA5A, 32'h0000_0300, 4'b0010, 32'hAAAA_5A00};
    vecs[8]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0000_0100, 4'b1100, 32'h1234_0000};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_0400, 4'b1111, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 3'b010, 32'h0000_0402, 32'hDEAD_BEEF, 32'h0000_0400, 4'b1111, 32'hBEEF_0000};
    vecs[11] = '{1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0123_4567, 32'hFFFF_FFFC, 4'b1111, 32'h0123_4567};
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    sf3 = '{3'b000, 3'b001, 3'b010};

    // ---------------- reset ----------------
    rst = 1'b0; flush = 1'b0;
    dispatch_valid = 1'b0; dispatch_tag = '0; dispatch_is_store = 1'b0; dispatch_funct3 = '0;
    agu_valid = 1'b0; agu_tag = '0; agu_addr = '0; agu_store_data = '0;
    rob_head_valid = 1'b0; rob_head_tag = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    cyc(); cyc();
    chk("rst_lsq_full", 32'(lsq_full), 32'd0);
    chk("rst_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_pulses", 32'({cdb_valid, store_done}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    cyc();

    // ---------------- table-driven single ops ----------------
    for (int i = 0; i < 12; i++) begin
      rob_head_valid = 1'b1; rob_head_tag = 2'(i);
      do_dispatch(2'(i), vecs[i].st, vecs[i].f3);
      do_agu(2'(i), vecs[i].addr, vecs[i].data, 1'b1);
      serve_op(2'(i), vecs[i].st, vecs[i].st ? $urandom : vecs[i].data,
               (i == 0) ? 2 : i % 2, vecs[i].exp_addr, vecs[i].exp_mask, vecs[i].exp_out);
    end
    rob_head_valid = 1'b0;

    // ---------------- store waits for ROB head ----------------
    rob_head_valid = 1'b1; rob_head_tag = 2'd0;
    do_dispatch(2'd2, 1'b1, 3'b001);
    do_agu(2'd2, 32'h0000_0102, 32'h0000_1234, 1'b1);
    repeat (4) cyc();
    chk("sh_blocked_wmask", 32'(dmem_wmask), 32'd0);
    chk("sh_blocked_state", 32'(dbg_state), 32'd0);
    rob_head_tag = 2'd2;
    serve_op(2'd2, 1'b1, 32'h0, 0, 32'h0000_0100, 4'b1100, 32'h1234_0000);
    rob_head_valid = 1'b0;

    // ---------------- fill, full drop, wrap ----------------
    for (int t = 0; t < 4; t++) do_dispatch(2'(t), 1'b0, 3'b010);
    chk("fill_full", 32'(lsq_full), 32'd1);
    do_dispatch(2'd0, 1'b1, 3'b000);               // dropped: queue full
    chk("fill_still_full", 32'(lsq_full), 32'd1);
    do_agu(2'd0, 32'h0000_0500, 32'h0, 1'b1);
    wait_req(ok);
    chk("fill_head_rmask", 32'(dmem_rmask), 32'hF);
    chk("fill_head_addr", dmem_addr, 32'h0000_0500);
    // dequeue and dispatch in the same cycle while full: dispatch is dropped
    dispatch_valid = 1'b1; dispatch_tag = 2'd0; dispatch_is_store = 1'b0; dispatch_funct3 = 3'b010;
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_0000;
    cyc();
    dispatch_valid = 1'b0; dmem_resp = 1'b0;
    chk("fill_cdb_valid", 32'(cdb_valid), 32'd1);
    chk("fill_cdb_tag", 32'(cdb_tag), 32'd0);
    chk("fill_cdb_data", cdb_data, 32'h1111_0000);
    chk("fill_deq_not_full", 32'(lsq_full), 32'd0);
    // dispatch into the wrapped slot while capturing another entry's address
    dispatch_valid = 1'b1; dispatch_tag = 2'd0; dispatch_is_store = 1'b0; dispatch_funct3 = 3'b010;
    agu_valid = 1'b1; agu_tag = 2'd1; agu_addr = 32'h0000_0504; agu_store_data = 32'h0;
    #1;
    chk("fill_agu_with_dispatch", 32'(agu_resp), 32'd1);
    cyc();
    dispatch_valid = 1'b0; agu_valid = 1'b0;
    chk("fill_wrap_full", 32'(lsq_full), 32'd1);
    do_agu(2'd2, 32'h0000_0508, 32'h0, 1'b1);
    do_agu(2'd3, 32'h0000_050C, 32'h0, 1'b1);
    do_agu(2'd0, 32'h0000_0510, 32'h0, 1'b1);
    serve_op(2'd1, 1'b0, 32'h2222_2222, 0, 32'h0000_0504, 4'hF, 32'h2222_2222);
    serve_op(2'd2, 1'b0, 32'h3333_3333, 1, 32'h0000_0508, 4'hF, 32'h3333_3333);
    serve_op(2'd3, 1'b0, 32'h4444_4444, 0, 32'h0000_050C, 4'hF, 32'h4444_4444);
    serve_op(2'd0, 1'b0, 32'h5555_5555, 0, 32'h0000_0510, 4'hF, 32'h5555_5555);
    chk("fill_drained_not_full", 32'(lsq_full), 32'd0);

    // ---------------- flush during WAIT, drain ----------------
    do_dispatch(2'd1, 1'b0, 3'b010);
    do_agu(2'd1, 32'h0000_0600, 32'h0, 1'b1);
    wait_req(ok);
    chk("flush_pre_rmask", 32'(dmem_rmask), 32'hF);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_state_drain", 32'(dbg_state), 32'd2);
    chk("flush_rmask_held", 32'(dmem_rmask), 32'hF);
    do_agu(2'd1, 32'h0000_0600, 32'h0, 1'b0);     // entry squashed
    cyc();
    dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    cyc();
    dmem_resp = 1'b0;
    chk("drain_no_cdb", 32'(cdb_valid | store_done), 32'd0);
    chk("drain_state_idle", 32'(dbg_state), 32'd0);
    chk("drain_rmask_clear", 32'(dmem_rmask), 32'd0);
    cyc();
    chk("drain_no_cdb_later", 32'(cdb_valid), 32'd0);
    // flush in the cycle the CDB pulse would be visible
    do_dispatch(2'd2, 1'b0, 3'b010);
    do_agu(2'd2, 32'h0000_0700, 32'h0, 1'b1);
    wait_req(ok);
    dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
    cyc();
    dmem_resp = 1'b0; flush = 1'b1;
    #1;
    chk("flush_kills_cdb", 32'(cdb_valid), 32'd0);
    cyc();
    flush = 1'b0;
    chk("flush_kills_cdb_after", 32'(cdb_valid), 32'd0);
    chk("flush_empty", 32'(lsq_full), 32'd0);

    // ---------------- async reset mid-WAIT ----------------
    do_dispatch(2'd3, 1'b0, 3'b010);
    for (int t = 0; t < 3; t++) do_dispatch(2'(t), 1'b0, 3'b010);
    do_agu(2'd3, 32'h0000_0800, 32'h0, 1'b1);
    wait_req(ok);
    chk("arst_pre_full", 32'(lsq_full), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("arst_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
    chk("arst_addr", dmem_addr, 32'd0);
    chk("arst_full", 32'(lsq_full), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    chk("arst_cdb_data", cdb_data, 32'd0);
    chk("arst_pulses", 32'({cdb_valid, store_done, cdb_tag, store_done_tag}), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // ---------------- randomized batches vs reference model ----------------
    for (int it = 0; it < 40; it++) begin
      rob_head_valid = 1'b0;
      k = $urandom_range(1, 4);
      tg = '{0, 1, 2, 3};
      for (int s = 3; s > 0; s--) begin
        r = $urandom_range(0, s); tmp = tg[s]; tg[s] = tg[r]; tg[r] = tmp;
      end
      for (int j = 0; j < k; j++) begin
        op.tag  = 2'(tg[j]);
        op.st   = 1'($urandom_range(0, 1));
        op.f3   = op.st ? sf3[$urandom_range(0, 2)] : lf3[$urandom_range(0, 4)];
        op.addr = $urandom;
        op.data = $urandom;
        op_q.push_back(op);
        do_dispatch(op.tag, op.st, op.f3);
      end
      chk("rnd_full", 32'(lsq_full), 32'(op_q.size() == 4));
      if (k < 4) do_agu(2'(tg[k]), $urandom, $urandom, 1'b0);
      ord = '{0, 1, 2, 3};
      for (int s = k - 1; s > 0; s--) begin
        r = $urandom_range(0, s); tmp = ord[s]; ord[s] = ord[r]; ord[r] = tmp;
      end
      for (int j = 0; j < k; j++)
        do_agu(op_q[ord[j]].tag, op_q[ord[j]].addr, op_q[ord[j]].data, 1'b1);
      do_agu(op_q[0].tag, $urandom, $urandom, 1'b0);
      while (op_q.size() > 0) begin
        cur = op_q.pop_front();
        rd  = $urandom;
        if (cur.st) begin
          if ($urandom_range(0, 1) == 0) rob_head_valid = 1'b0;
          else begin rob_head_valid = 1'b1; rob_head_tag = cur.tag ^ 2'b01; end
          cyc(); cyc();
          chk("rnd_store_blocked", 32'(dmem_rmask | dmem_wmask), 32'd0);
          rob_head_valid = 1'b1; rob_head_tag = cur.tag;
          eo = ref_wdata(cur.addr, cur.data);
        end else begin
          eo = ref_load(cur.f3, cur.addr, rd);
        end
        serve_op(cur.tag, cur.st, rd, $urandom_range(0, 2), cur.addr & 32'hFFFF_FFFC,
                 ref_mask(cur.f3, cur.addr), eo);
        rob_head_valid = 1'b0;
      end
      chk("rnd_idle", 32'(dbg_state), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
